// File: rtl/tuning_word_decode.sv
// tuning_word_decode: turns a 28-bit DDS tuning word M back into its output
// frequency in kHz as four BCD digits (C5 thousands .. C2 units).
// The decode is sequential: a 1-bit/cycle restoring divide by K, a clamp to
// QMAX (flagging OVF), then a 14-step double-dabble.
// Optional build macro: TWD_ROUND_EN. When it is defined, K/2 is added to the
// dividend so the result rounds half up. The divide then runs MW+1 steps, so
// the latency is 44 clocks instead of 43.
module tuning_word_decode #(
   parameter int K    = 26844,
   parameter int MW   = 28,
   parameter int QMAX = 9999
) (
   input  logic          CLOCK_50,
   input  logic          KEY1,
   input  logic          START,
   input  logic [MW-1:0] M,
   output logic          BUSY,
   output logic          DONE,
   output logic          OVF,
   output logic [3:0]    C2,
   output logic [3:0]    C3,
   output logic [3:0]    C4,
   output logic [3:0]    C5
);

`ifdef TWD_ROUND_EN
   localparam int DW = MW + 1;
`else
   localparam int DW = MW;
`endif
   localparam int CW = $clog2(DW);

   localparam logic [15:0]   K_W     = 16'(K);
   localparam logic [DW-1:0] QMAX_W  = DW'(QMAX);
   localparam logic [13:0]   QMAX_14 = 14'(QMAX);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_BCD  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state;
   logic [DW-1:0]   dvd;       // dividend, shifted left one bit per step
   logic [DW-1:0]   quo;       // quotient, bits enter at the LSB
   logic [15:0]     rem;       // partial remainder, always < K
   logic [CW-1:0]   cnt;       // divide steps remaining minus one
   logic [29:0]     dd;        // double-dabble register {bcd[15:0], bin[13:0]}
   logic [3:0]      dd_cnt;    // BCD steps remaining minus one
   logic            ovf_pend;  // clamp happened; published with the digits
   logic            done_ph;   // second cycle of DONE (pulse already issued)

   logic [DW-1:0]   dvd_init;
   logic [15:0]     rem_sh;
   logic            q_bit;
   logic [15:0]     rem_nx;
   logic [DW-1:0]   quo_nx;
   logic            sat;
   logic [29:0]     dd_adj;
   logic [29:0]     dd_nx;

   // Dividend loaded on acceptance; the rounding build adds K/2 in MW+1 bits.
   always_comb begin
`ifdef TWD_ROUND_EN
      dvd_init = {1'b0, M} + DW'(K >> 1);
`else
      dvd_init = M;
`endif
   end

   // One restoring-division step plus the clamp test on the resulting quotient.
   always_comb begin
      rem_sh = {rem[14:0], dvd[DW-1]};
      q_bit  = (rem_sh >= K_W);
      rem_nx = q_bit ? (rem_sh - K_W) : rem_sh;
      quo_nx = {quo[DW-2:0], q_bit};
      sat    = (quo_nx > QMAX_W);
   end

   // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
   always_comb begin
      dd_adj = dd;
      for (int i = 0; i < 4; i++) begin
         if (dd[14 + 4*i +: 4] >= 4'd5) begin
            dd_adj[14 + 4*i +: 4] = dd[14 + 4*i +: 4] + 4'd3;
         end
      end
      dd_nx = {dd_adj[28:0], 1'b0};
   end

   // Control FSM with datapath; every output is a register.
   always_ff @(posedge CLOCK_50) begin
      if (!KEY1) begin
         state    <= S_IDLE;
         dvd      <= '0;
         quo      <= '0;
         rem      <= '0;
         cnt      <= '0;
         dd       <= '0;
         dd_cnt   <= '0;
         ovf_pend <= 1'b0;
         done_ph  <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         OVF      <= 1'b0;
         C2       <= '0;
         C3       <= '0;
         C4       <= '0;
         C5       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  dvd   <= dvd_init;
                  quo   <= '0;
                  rem   <= '0;
                  cnt   <= CW'(DW - 1);
                  BUSY  <= 1'b1;
                  state <= S_DIV;
               end
            end
            S_DIV: begin
               dvd <= {dvd[DW-2:0], 1'b0};
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  // Last quotient bit is in quo_nx; clamp and seed the BCD pass.
                  dd       <= {16'd0, (sat ? QMAX_14 : quo_nx[13:0])};
                  ovf_pend <= sat;
                  dd_cnt   <= 4'd13;
                  state    <= S_BCD;
               end
            end
            S_BCD: begin
               dd      <= dd_nx;
               dd_cnt  <= dd_cnt - 1'b1;
               done_ph <= 1'b0;
               if (dd_cnt == 4'd0) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (!done_ph) begin
                  // Publish digits; they hold until the next completed decode.
                  C5      <= dd[29:26];
                  C4      <= dd[25:22];
                  C3      <= dd[21:18];
                  C2      <= dd[17:14];
                  OVF     <= ovf_pend;
                  DONE    <= 1'b1;
                  done_ph <= 1'b1;
               end else begin
                  DONE    <= 1'b0;
                  done_ph <= 1'b0;
                  BUSY    <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
               DONE  <= 1'b0;
            end
         endcase
      end
   end

endmodule
